btb_update_queue: RTL and testbench
===================================

BTB_UPDATE_QUEUE -- requirements
Module: btb_update_queue

Interface
REQ-001 Parameter PC_BITS, default 32: width of every PC/target field.
REQ-002 Parameter DEPTH, default 4: queue entries, power of two, >= 2.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 valid_in  input  1  resolved-branch update offered this cycle.
REQ-006 ready_out  output  1  queue can accept an update this cycle.
REQ-007 pc_in  input  PC_BITS  originating PC of the resolved branch.
REQ-008 target_in  input  PC_BITS  resolved target PC.
REQ-009 taken_in  input  1  1 = install/refresh entry, 0 = remove entry.
REQ-010 hold  input  1  1 = inhibit draining this cycle (e.g. during a predictor flush).
REQ-011 Wr_En  output  1  BTB write strobe.
REQ-012 Orig_PC  output  PC_BITS  BTB write originating PC.
REQ-013 Target_PC  output  PC_BITS  BTB write target PC.
REQ-014 invalidate  output  1  BTB invalidation strobe.
REQ-015 pc_invalid  output  PC_BITS  PC whose BTB line is invalidated.
REQ-016 count_out  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-017 Circular FIFO: wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0; count of $clog2(DEPTH)+1 bits.
REQ-018 ready_out = (count != DEPTH); depends only on current state, not on same-cycle pop.
REQ-019 Accept = valid_in & ready_out; valid_in while ready_out=0 is dropped, no state change.
REQ-020 Merge: on accept, if count > 0, youngest entry (wr_ptr-1) is not being popped this cycle, and its pc equals pc_in, then overwrite that entry's target and taken; wr_ptr and count unchanged.
REQ-021 Otherwise accept pushes {pc_in, target_in, taken_in} at wr_ptr; wr_ptr increments.
REQ-022 Pop = (count != 0) & !hold; at most one entry drained per cycle, head at rd_ptr.
REQ-023 Head taken=1 and pop: Wr_En=1, Orig_PC=head.pc, Target_PC=head.target, invalidate=0.
REQ-024 Head taken=0 and pop: invalidate=1, pc_invalid=head.pc, Wr_En=0.
REQ-025 No pop: Wr_En=0 and invalidate=0; Orig_PC/Target_PC/pc_invalid reflect head fields (don't-care when empty).
REQ-026 Wr_En and invalidate are never both 1 in the same cycle.
REQ-027 Outputs are combinational from head storage; update accepted at edge N drives BTB no earlier than cycle N+1 (no same-cycle bypass).
REQ-028 Simultaneous push and pop: count unchanged, both pointers advance; legal when full is impossible (ready_out=0 blocks push).
REQ-029 Simultaneous merge and pop of a different entry: count decrements by 1.
REQ-030 Updates drain in acceptance order; a merged entry keeps its original queue position.
REQ-031 count_out = count.

Reset
REQ-032 While rst_n=0 at a rising edge: wr_ptr=0, rd_ptr=0, count=0; storage not reset.
REQ-033 After reset: ready_out=1, Wr_En=0, invalidate=0, count_out=0.
REQ-034 Reset mid-operation discards all queued updates; no strobe asserts in the cycle following reset.

Structure
REQ-035 Shared predictor package holds struct btb_upd_t {pc, target, taken} parameterised by PC_BITS and the DEPTH default.
REQ-036 Single module, no sub-modules; storage is a flat array of btb_upd_t, no SRAM macro.

Verification
REQ-037 Reset, then push pc=0x100 tgt=0x200 taken=1, hold=0 -> next cycle Wr_En=1, Orig_PC=0x100, Target_PC=0x200; following cycle count_out=0.
REQ-038 hold=1, push 4 distinct taken updates -> count_out=4, ready_out=0; 5th valid_in dropped; release hold -> 4 Wr_En pulses in order.
REQ-039 hold=1, push pc=0x40 tgt=0x80 then pc=0x40 tgt=0x90 taken=0 -> count_out=1; release -> single invalidate=1, pc_invalid=0x40, Wr_En=0.
REQ-040 Steady valid_in every cycle with hold=0 and distinct PCs -> count_out stays 1, one strobe per cycle, pointers wrap past DEPTH-1 without loss.
REQ-041 Full queue, rst_n=0 for one cycle -> count_out=0, ready_out=1, no Wr_En/invalidate until new pushes.
REQ-042 count=1 head pc=0x40 popping while pc_in=0x40 arrives -> pushed as new entry (no merge); two strobes observed.

Source files
------------

// File: rtl/btb_update_queue_pkg.sv
// Shared predictor types for the BTB update queue.
// Holds the queued update record and the default queue geometry.
package btb_update_queue_pkg;

  localparam int BTB_PC_BITS  = 32;
  localparam int BTB_UQ_DEPTH = 4;

  typedef struct packed {
    logic [BTB_PC_BITS-1:0] pc;
    logic [BTB_PC_BITS-1:0] target;
    logic                   taken;
  } btb_upd_t;

endpackage

// File: rtl/btb_update_queue.sv
// Queues resolved-branch updates and drains one per cycle into the BTB.
// Ports: clk/rst_n (sync, active low); valid_in/ready_out/pc_in/target_in/
// taken_in offer an update; hold stalls draining; Wr_En/Orig_PC/Target_PC
// write the BTB; invalidate/pc_invalid remove a line; count_out = occupancy.
module btb_update_queue
  import btb_update_queue_pkg::*;
#(
  parameter int PC_BITS = BTB_PC_BITS,
  parameter int DEPTH   = BTB_UQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_in,
  output logic                     ready_out,
  input  logic [PC_BITS-1:0]       pc_in,
  input  logic [PC_BITS-1:0]       target_in,
  input  logic                     taken_in,
  input  logic                     hold,
  output logic                     Wr_En,
  output logic [PC_BITS-1:0]       Orig_PC,
  output logic [PC_BITS-1:0]       Target_PC,
  output logic                     invalidate,
  output logic [PC_BITS-1:0]       pc_invalid,
  output logic [$clog2(DEPTH):0]   count_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  btb_upd_t mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] young_ptr;
  logic [CW-1:0] count;

  logic     accept;
  logic     pop;
  logic     merge;
  logic     push;
  btb_upd_t head;

  assign young_ptr = wr_ptr - AW'(1);
  assign ready_out = (count != CW'(DEPTH));
  assign accept    = valid_in & ready_out;
  assign pop       = (count != '0) & ~hold;

  // Folding into the youngest entry is only safe while it stays queued;
  // if it is the head being drained now, the update must be re-queued.
  assign merge = accept & (count != '0)
               & ~(pop & (young_ptr == rd_ptr))
               & (mem[young_ptr].pc[PC_BITS-1:0] == pc_in);

  assign push = accept & ~merge;

  assign head       = mem[rd_ptr];
  assign Orig_PC    = head.pc[PC_BITS-1:0];
  assign Target_PC  = head.target[PC_BITS-1:0];
  assign pc_invalid = head.pc[PC_BITS-1:0];
  assign Wr_En      = pop & head.taken;
  assign invalidate = pop & ~head.taken;
  assign count_out  = count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr].pc     <= BTB_PC_BITS'(pc_in);
      mem[wr_ptr].target <= BTB_PC_BITS'(target_in);
      mem[wr_ptr].taken  <= taken_in;
    end else if (merge) begin
      mem[young_ptr].target <= BTB_PC_BITS'(target_in);
      mem[young_ptr].taken  <= taken_in;
    end
  end

endmodule

// File: tb/tb_btb_update_queue.sv
// Directed bench for btb_update_queue.
// Each row drives inputs for one cycle and checks outputs before the edge.
module tb_btb_update_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] pc_in;
  logic [31:0] target_in;
  logic        taken_in;
  logic        hold;
  logic        Wr_En;
  logic [31:0] Orig_PC;
  logic [31:0] Target_PC;
  logic        invalidate;
  logic [31:0] pc_invalid;
  logic [2:0]  count_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  btb_update_queue #(.PC_BITS(32), .DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .pc_in      (pc_in),
    .target_in  (target_in),
    .taken_in   (taken_in),
    .hold       (hold),
    .Wr_En      (Wr_En),
    .Orig_PC    (Orig_PC),
    .Target_PC  (Target_PC),
    .invalidate (invalidate),
    .pc_invalid (pc_invalid),
    .count_out  (count_out)
  );

  typedef struct {
    logic        rst;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        tk;
    logic        hld;
    logic        e_rdy;
    logic        e_wr;
    logic        e_inv;
    logic [31:0] e_pc;
    logic [31:0] e_tgt;
    int          e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic rst, logic vld, logic [31:0] pc, logic [31:0] tgt,
    logic tk, logic hld, logic e_rdy, logic e_wr, logic e_inv,
    logic [31:0] e_pc, logic [31:0] e_tgt, int e_cnt);
    vec_t v;
    v.rst = rst; v.vld = vld; v.pc = pc; v.tgt = tgt;
    v.tk = tk; v.hld = hld; v.e_rdy = e_rdy; v.e_wr = e_wr;
    v.e_inv = e_inv; v.e_pc = e_pc; v.e_tgt = e_tgt;
    v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(string nm, int idx, logic [31:0] act,
                     logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got 0x%0h, want 0x%0h",
               nm, idx, act, exp);
    end
  endtask

  task automatic drive(logic r, logic v, logic [31:0] p,
                       logic [31:0] t, logic k, logic h);
    rst_n = r; valid_in = v; pc_in = p;
    target_in = t; taken_in = k; hold = h;
  endtask

  task automatic check_row(int i, vec_t v);
    chk("count", i, 32'(count_out), 32'(v.e_cnt));
    chk("ready", i, 32'(ready_out), 32'(v.e_rdy));
    chk("wr_en", i, 32'(Wr_En), 32'(v.e_wr));
    chk("inval", i, 32'(invalidate), 32'(v.e_inv));
    chk("excl", i, 32'(Wr_En & invalidate), 32'd0);
    if (v.e_wr) begin
      chk("orig_pc", i, Orig_PC, v.e_pc);
      chk("tgt_pc", i, Target_PC, v.e_tgt);
    end
    if (v.e_inv) chk("pc_inv", i, pc_invalid, v.e_pc);
  endtask

  initial begin
    // rst vld pc tgt tk hold | rdy wr inv pc tgt cnt
    // basic push then drain
    tbl.push_back(mk(1,1,'h100,'h200,1,0, 1,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0, 1,1,0,'h100,'h200,1));
    tbl.push_back(mk(1,0,0,0,0,0, 1,0,0,0,0,0));
    // fill under hold, drop 5th, drain in order
    tbl.push_back(mk(1,1,'h110,'h210,1,1, 1,0,0,0,0,0));
    tbl.push_back(mk(1,1,'h120,'h220,1,1, 1,0,0,0,0,1));
    tbl.push_back(mk(1,1,'h130,'h230,1,1, 1,0,0,0,0,2));
    tbl.push_back(mk(1,1,'h140,'h240,1,1, 1,0,0,0,0,3));
    tbl.push_back(mk(1,1,'h150,'h250,1,1, 0,0,0,0,0,4));
    tbl.push_back(mk(1,0,0,0,0,0, 0,1,0,'h110,'h210,4));
    tbl.push_back(mk(1,0,0,0,0,0, 1,1,0,'h120,'h220,3));
    tbl.push_back(mk(1,0,0,0,0,0, 1,1,0,'h130,'h230,2));
    tbl.push_back(mk(1,0,0,0,0,0, 1,1,0,'h140,'h240,1));
    tbl.push_back(mk(1,0,0,0,0,0, 1,0,0,0,0,0));
    // merge same pc into a removal
    tbl.push_back(mk(1,1,'h40,'h80,1,1, 1,0,0,0,0,0));
    tbl.push_back(mk(1,1,'h40,'h90,0,1, 1,0,0,0,0,1));
    tbl.push_back(mk(1,0,0,0,0,1, 1,0,0,0,0,1));
    tbl.push_back(mk(1,0,0,0,0,0, 1,0,1,'h40,0,1));
    tbl.push_back(mk(1,0,0,0,0,0, 1,0,0,0,0,0));
    // streaming, pointers wrap
    tbl.push_back(mk(1,1,'h200,'h300,1,0, 1,0,0,0,0,0));
    tbl.push_back(mk(1,1,'h204,'h304,1,0, 1,1,0,'h200,'h300,1));
    tbl.push_back(mk(1,1,'h208,'h308,0,0, 1,1,0,'h204,'h304,1));
    tbl.push_back(mk(1,1,'h20c,'h30c,1,0, 1,0,1,'h208,0,1));
    tbl.push_back(mk(1,1,'h210,'h310,1,0, 1,1,0,'h20c,'h30c,1));
    tbl.push_back(mk(1,0,0,0,0,0, 1,1,0,'h210,'h310,1));
    tbl.push_back(mk(1,0,0,0,0,0, 1,0,0,0,0,0));
    // same pc arriving while head pops: no merge
    tbl.push_back(mk(1,1,'h40,'h50,1,0, 1,0,0,0,0,0));
    tbl.push_back(mk(1,1,'h40,'h60,1,0, 1,1,0,'h40,'h50,1));
    tbl.push_back(mk(1,0,0,0,0,0, 1,1,0,'h40,'h60,1));
    tbl.push_back(mk(1,0,0,0,0,0, 1,0,0,0,0,0));
    // merge into youngest while a different head pops
    tbl.push_back(mk(1,1,'h500,'h600,1,1, 1,0,0,0,0,0));
    tbl.push_back(mk(1,1,'h504,'h604,1,1, 1,0,0,0,0,1));
    tbl.push_back(mk(1,1,'h504,'h608,0,0, 1,1,0,'h500,'h600,2));
    tbl.push_back(mk(1,0,0,0,0,0, 1,0,1,'h504,0,1));
    tbl.push_back(mk(1,0,0,0,0,0, 1,0,0,0,0,0));
    // reset with a full queue
    tbl.push_back(mk(1,1,'h700,'h710,1,1, 1,0,0,0,0,0));
    tbl.push_back(mk(1,1,'h704,'h714,1,1, 1,0,0,0,0,1));
    tbl.push_back(mk(1,1,'h708,'h718,1,1, 1,0,0,0,0,2));
    tbl.push_back(mk(1,1,'h70c,'h71c,1,1, 1,0,0,0,0,3));
    tbl.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0,4));
    tbl.push_back(mk(1,0,0,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(1,1,'h800,'h900,1,0, 1,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0, 1,1,0,'h800,'h900,1));
    tbl.push_back(mk(1,0,0,0,0,0, 1,0,0,0,0,0));

    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].vld, tbl[i].pc, tbl[i].tgt,
            tbl[i].tk, tbl[i].hld);
      #1;
      check_row(i, tbl[i]);
    end

    // full queue rejects even a matching pc; originals drain intact
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1, 1, 32'h0a00 + 32'(4 * k), 32'h0b00 + 32'(k), 1, 1);
    end
    @(negedge clk);
    drive(1, 1, 32'h0a0c, 32'h0eee, 0, 1);
    #1;
    chk("full_cnt", 100, 32'(count_out), 32'd4);
    chk("full_rdy", 100, 32'(ready_out), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 0);
      #1;
      chk("drain_wr", 101 + k, 32'(Wr_En), 32'd1);
      chk("drain_pc", 101 + k, Orig_PC, 32'h0a00 + 32'(4 * k));
      chk("drain_tgt", 101 + k, Target_PC, 32'h0b00 + 32'(k));
    end
    @(negedge clk);
    #1;
    chk("empty_cnt", 105, 32'(count_out), 32'd0);
    chk("empty_inv", 105, 32'(invalidate), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
